output_layer_collector: RTL and testbench

//  Writer side of the digit_weights / network_done interface. Collects the output-layer

---
 rtl/output_layer_collector.sv | 111 +++++++++++
 tb/tb_output_layer_collector.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/output_layer_collector.sv
// Collects serial output-layer sigmoid samples into a parallel digit weight bank and
// pulses network_done when a complete bank is published. Optional INDEX_CHECK_EN adds index checking.
module output_layer_collector #(
  parameter int unsigned NUM_DIGITS  = 10,
  parameter int unsigned WEIGHT_BITS = 4,
  parameter int unsigned CNT_BITS    = 4
) (
  input  logic                                    clk,
  input  logic                                    n_rst,
  input  logic                                    layer_start,
  input  logic                                    sig_valid,
  input  logic [WEIGHT_BITS-1:0]                  sig_data,
`ifdef INDEX_CHECK_EN
  input  logic [CNT_BITS-1:0]                     sig_index,
  output logic                                    index_err,
`endif
  output logic                                    sig_ready,
  output logic [0:NUM_DIGITS-1][WEIGHT_BITS-1:0]  digit_weights,
  output logic                                    network_done,
  output logic                                    busy
);

  localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t                                  r_state;
  state_t                                  w_state_next;
  logic [CNT_BITS-1:0]                     r_sample_cnt;
  logic [0:NUM_DIGITS-1][WEIGHT_BITS-1:0]  r_shadow;
  logic [0:NUM_DIGITS-1][WEIGHT_BITS-1:0]  w_bank;
  logic                                    w_accept;
  logic                                    w_last;
  logic                                    w_abort;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (layer_start) w_state_next = S_COLLECT;
      S_COLLECT: if (w_accept && w_last) w_state_next = S_DONE;
      S_DONE:    w_state_next = layer_start ? S_COLLECT : S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // layer_start in COLLECT wins over a sample offered in the same cycle
  always_comb begin
    sig_ready    = 1'b0;
    busy         = 1'b0;
    network_done = 1'b0;
    w_abort      = 1'b0;
    case (r_state)
      S_COLLECT: begin
        busy      = 1'b1;
        sig_ready = !layer_start;
        w_abort   = layer_start;
      end
      S_DONE:    network_done = 1'b1;
      default:   ;
    endcase
    w_accept = sig_valid && sig_ready;
    w_last   = (r_sample_cnt == LAST_IDX);
  end

  // Shadow bank with the current sample merged in, so completion publishes all entries at once
  always_comb begin
    w_bank = r_shadow;
    if (w_accept) w_bank[r_sample_cnt] = sig_data;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_sample_cnt  <= '0;
      r_shadow      <= '0;
      digit_weights <= '0;
    end else if (w_abort) begin
      r_sample_cnt <= '0;
    end else if (w_accept) begin
      r_shadow <= w_bank;
      if (w_last) begin
        r_sample_cnt  <= '0;
        digit_weights <= w_bank;
      end else begin
        r_sample_cnt <= r_sample_cnt + CNT_BITS'(1);
      end
    end
  end

`ifdef INDEX_CHECK_EN
  // Sticky until a new layer is started from IDLE or DONE
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      index_err <= 1'b0;
    end else if (layer_start && (r_state != S_COLLECT)) begin
      index_err <= 1'b0;
    end else if (w_accept && (sig_index != r_sample_cnt)) begin
      index_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_output_layer_collector.sv
// Directed self-checking bench for output_layer_collector (index checks when INDEX_CHECK_EN is set).
module tb_output_layer_collector;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              layer_start;
  logic              sig_valid;
  logic [3:0]        sig_data;
  logic              sig_ready;
  logic [0:9][3:0]   digit_weights;
  logic              network_done;
  logic              busy;
`ifdef INDEX_CHECK_EN
  logic [3:0]        sig_index;
  logic              index_err;
`endif

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int n_done = 0;

  logic [3:0] v1 [10] = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 4'd2, 4'd6, 4'd5, 4'd3};

  always #5 clk = ~clk;

  output_layer_collector #(
    .NUM_DIGITS(10), .WEIGHT_BITS(4), .CNT_BITS(4)
  ) dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .layer_start   (layer_start),
    .sig_valid     (sig_valid),
    .sig_data      (sig_data),
`ifdef INDEX_CHECK_EN
    .sig_index     (sig_index),
    .index_err     (index_err),
`endif
    .sig_ready     (sig_ready),
    .digit_weights (digit_weights),
    .network_done  (network_done),
    .busy          (busy)
  );

  always @(negedge clk) if (network_done === 1'b1) n_done++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] v);
    sig_valid = 1'b1;
    sig_data  = v;
    tick();
    sig_valid = 1'b0;
  endtask

  task automatic start_layer();
    layer_start = 1'b1;
    tick();
    layer_start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    n_rst = 1'b0; layer_start = 1'b0; sig_valid = 1'b0; sig_data = '0;
`ifdef INDEX_CHECK_EN
    sig_index = '0;
`endif
    #12;
    check("rst_weights", 64'(digit_weights), 64'd0);
    check("rst_done",    64'(network_done),  64'd0);
    check("rst_busy",    64'(busy),          64'd0);
    check("rst_ready",   64'(sig_ready),     64'd0);
`ifdef INDEX_CHECK_EN
    check("rst_index_err", 64'(index_err), 64'd0);
`endif
    n_rst = 1'b1;
    tick();

    // Back-to-back layer
    start_layer();
    #1;
    check("t1_busy",  64'(busy),      64'd1);
    check("t1_ready", 64'(sig_ready), 64'd1);
    for (int i = 0; i < 9; i++) send(v1[i]);
    check("t1_no_early_done", 64'(network_done), 64'd0);
    send(v1[9]);
    check("t1_done",    64'(network_done),  64'd1);
    check("t1_weights", 64'(digit_weights), 64'h3141592653);
    check("t1_busy_done", 64'(busy), 64'd0);
    tick();
    check("t1_done_clear", 64'(network_done), 64'd0);
    check("t1_pulses",     64'(n_done),       64'd1);

    // Gapped layer
    start_layer();
    for (int i = 0; i < 10; i++) begin
      send(v1[i]);
      if (i < 9) begin
        for (int g = 0; g < (i % 4); g++) begin
          tick();
          check("t2_busy_gap", 64'(busy), 64'd1);
        end
        check("t2_no_early_done", 64'(network_done), 64'd0);
      end
    end
    check("t2_done",    64'(network_done),  64'd1);
    check("t2_weights", 64'(digit_weights), 64'h3141592653);
    tick();
    check("t2_pulses", 64'(n_done), 64'd2);

    // Bank A, then layer_start during DONE, partial abort, bank B
    start_layer();
    for (int i = 0; i < 10; i++) send(4'h7);
    check("t3_doneA",    64'(network_done),  64'd1);
    check("t3_weightsA", 64'(digit_weights), 64'h7777777777);
    layer_start = 1'b1;
    #1;
    check("t3_ready_in_done", 64'(sig_ready), 64'd0);
    tick();
    layer_start = 1'b0;
    check("t3_busy_after_done_start", 64'(busy), 64'd1);
    check("t3_done_one_cycle", 64'(network_done), 64'd0);
    for (int i = 0; i < 6; i++) send(4'hF);
    check("t3_hold_partial", 64'(digit_weights), 64'h7777777777);
    start_layer();
    check("t3_abort_busy", 64'(busy), 64'd1);
    for (int i = 0; i < 9; i++) send(4'(i));
    check("t3_hold_before_B", 64'(digit_weights), 64'h7777777777);
    check("t3_no_abort_pulse", 64'(n_done), 64'd3);
    send(4'd9);
    check("t3_doneB",    64'(network_done),  64'd1);
    check("t3_weightsB", 64'(digit_weights), 64'h0123456789);
    tick();
    check("t3_pulses", 64'(n_done), 64'd4);

    // sig_valid in IDLE, then layer_start colliding with a sample in COLLECT
    sig_valid = 1'b1; sig_data = 4'hE;
    #1;
    check("t4_ready_idle", 64'(sig_ready), 64'd0);
    tick();
    sig_valid = 1'b0;
    check("t4_idle_stays", 64'(busy), 64'd0);
    start_layer();
    for (int i = 0; i < 3; i++) send(4'h1);
    layer_start = 1'b1; sig_valid = 1'b1; sig_data = 4'hE;
    #1;
    check("t4_ready_collide", 64'(sig_ready), 64'd0);
    tick();
    layer_start = 1'b0; sig_valid = 1'b0;
    for (int i = 0; i < 9; i++) send(4'(9 - i));
    check("t4_no_early_done", 64'(network_done), 64'd0);
    send(4'd0);
    check("t4_done",    64'(network_done),  64'd1);
    check("t4_weights", 64'(digit_weights), 64'h9876543210);
    tick();

    // Reset in the middle of a layer
    start_layer();
    for (int i = 0; i < 5; i++) send(4'h2);
    #2;
    n_rst = 1'b0;
    #1;
    check("t5_rst_weights", 64'(digit_weights), 64'd0);
    check("t5_rst_done",    64'(network_done),  64'd0);
    check("t5_rst_busy",    64'(busy),          64'd0);
    check("t5_rst_ready",   64'(sig_ready),     64'd0);
    #2;
    n_rst = 1'b1;
    tick();
    start_layer();
    for (int i = 0; i < 9; i++) send(4'h2);
    check("t5_no_early_done", 64'(network_done),  64'd0);
    check("t5_still_zero",    64'(digit_weights), 64'd0);
    send(4'h2);
    check("t5_done",    64'(network_done),  64'd1);
    check("t5_weights", 64'(digit_weights), 64'h2222222222);
    tick();

`ifdef INDEX_CHECK_EN
    // Out-of-order index in slot 3
    start_layer();
    check("t6_err_cleared", 64'(index_err), 64'd0);
    for (int i = 0; i < 10; i++) begin
      sig_index = (i == 3) ? 4'd5 : 4'(i);
      send(4'(i));
      if (i == 2) check("t6_err_before", 64'(index_err), 64'd0);
      if (i == 3) check("t6_err_set",    64'(index_err), 64'd1);
    end
    check("t6_done",     64'(network_done),  64'd1);
    check("t6_err_done", 64'(index_err),     64'd1);
    check("t6_weights",  64'(digit_weights), 64'h0123456789);
    tick();
    check("t6_err_idle", 64'(index_err), 64'd1);
    start_layer();
    check("t6_err_restart", 64'(index_err), 64'd0);
    start_layer();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
